// File: rtl/loader_defs.sv
// Shared definitions for the instruction loader: FSM encoding and stream framing constants.
package loader_defs;

    typedef enum logic [2:0] {
        ST_LEN0 = 3'd0,
        ST_LEN1 = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    localparam int unsigned HDR_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned IDX_W      = $clog2(WORD_BYTES);

    function automatic logic takes_bytes(input state_t s);
        return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/inst_loader_packer.sv
// Little-endian byte-to-word packer; flags the byte that completes a 32-bit word.
module inst_loader_packer
    import loader_defs::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic        o_word_done,
    output logic [31:0] o_word
);

    logic [IDX_W-1:0] r_idx;
    logic [23:0]      r_shift;

    // Earlier bytes shift down so byte 0 ends up in bits 7:0 when the 4th arrives.
    assign o_word_done = i_accept && (r_idx == IDX_W'(WORD_BYTES - 1));
    assign o_word      = {i_byte, r_shift};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx   <= '0;
            r_shift <= '0;
        end else if (i_clear) begin
            r_idx   <= '0;
            r_shift <= '0;
        end else if (i_accept) begin
            r_idx   <= r_idx + 1'b1;
            r_shift <= {i_byte, r_shift[23:8]};
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Streams a length-prefixed, XOR-checksummed program image into instruction memory
// and releases the core from reset only once the checksum matches.
//
// state | meaning
// LEN0  | waiting for word count low byte
// LEN1  | waiting for word count high byte
// DATA  | receiving instruction words
// CSUM  | waiting for checksum byte
// DONE  | image good, core released
// ERR   | overflow or checksum mismatch, core held
module inst_loader
    import loader_defs::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              load_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst_n,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    state_t            r_state;
    state_t            w_next;
    logic [15:0]       r_len;
    logic [15:0]       r_word_cnt;
    logic [7:0]        r_csum;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_core_rst_n;
    logic              r_load_done;
    logic              r_load_err;

    logic              w_accept;
    logic              w_restart;
    logic              w_word_done;
    logic [31:0]       w_word;
    logic [15:0]       w_len_full;
    logic              w_last_word;

    assign rx_ready    = takes_bytes(r_state);
    assign w_accept    = rx_valid && rx_ready;
    assign w_restart   = load_req && ((r_state == ST_DONE) || (r_state == ST_ERR));
    assign w_len_full  = {rx_data, r_len[7:0]};
    assign w_last_word = (r_word_cnt == (r_len - 16'd1));

    inst_loader_packer u_packer (
        .i_clk       (sys_clk),
        .i_rst       (sys_rst),
        .i_clear     (w_restart),
        .i_accept    (w_accept && (r_state == ST_DATA)),
        .i_byte      (rx_data),
        .o_word_done (w_word_done),
        .o_word      (w_word)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) r_state <= ST_LEN0;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_LEN0: if (w_accept) w_next = ST_LEN1;
            ST_LEN1: begin
                if (w_accept) begin
                    if ({1'b0, w_len_full} > MAX_WORDS) w_next = ST_ERR;
                    else if (w_len_full == 16'd0)       w_next = ST_CSUM;
                    else                                w_next = ST_DATA;
                end
            end
            ST_DATA: if (w_word_done && w_last_word) w_next = ST_CSUM;
            ST_CSUM: if (w_accept) w_next = (rx_data == r_csum) ? ST_DONE : ST_ERR;
            ST_DONE: if (load_req) w_next = ST_LEN0;
            ST_ERR:  if (load_req) w_next = ST_LEN0;
            default: w_next = ST_LEN0;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_csum      <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_we <= w_word_done;
            if (w_word_done) begin
                r_mem_addr  <= r_word_cnt[ADDR_W-1:0];
                r_mem_wdata <= w_word;
            end
            if (w_restart) begin
                r_len      <= '0;
                r_word_cnt <= '0;
                r_csum     <= '0;
            end else begin
                if (w_word_done) r_word_cnt <= r_word_cnt + 16'd1;
                // Checksum covers header and data, never the checksum byte itself.
                if (w_accept && (r_state != ST_CSUM)) r_csum <= r_csum ^ rx_data;
                if (w_accept && (r_state == ST_LEN0)) r_len[7:0]  <= rx_data;
                if (w_accept && (r_state == ST_LEN1)) r_len[15:8] <= rx_data;
            end
        end
    end

    // Status flags follow the next state so they rise on the DONE/ERR entry edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_core_rst_n <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_core_rst_n <= (w_next == ST_DONE);
            r_load_done  <= (w_next == ST_DONE);
            r_load_err   <= (w_next == ST_ERR);
        end
    end

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign core_rst_n = r_core_rst_n;
    assign load_done  = r_load_done;
    assign load_err   = r_load_err;

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: streams built from word lists, writes checked by a monitor.
module tb_inst_loader;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        load_req = 1'b0;
    logic        rx_ready, mem_we, core_rst_n, load_done, load_err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;

    logic        rx_valid2 = 1'b0;
    logic [7:0]  rx_data2 = 8'h00;
    logic        load_req2 = 1'b0;
    logic        rx_ready2, mem_we2, core_rst_n2, load_done2, load_err2;
    logic [1:0]  mem_addr2;
    logic [31:0] mem_wdata2;

    int          n_cmp = 0;
    int          n_err = 0;
    int          we2_cnt = 0;
    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] words_q[$];
    logic [7:0]  stim_q[$];

    always #5 clk = ~clk;

    inst_loader #(.ADDR_W(10)) dut (
        .sys_clk(clk), .sys_rst(sys_rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .load_req(load_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .core_rst_n(core_rst_n), .load_done(load_done), .load_err(load_err)
    );

    inst_loader #(.ADDR_W(2)) dut2 (
        .sys_clk(clk), .sys_rst(sys_rst), .rx_valid(rx_valid2), .rx_data(rx_data2),
        .rx_ready(rx_ready2), .load_req(load_req2), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .core_rst_n(core_rst_n2), .load_done(load_done2), .load_err(load_err2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: every mem_we pulse must match the oldest expected write.
    always @(posedge clk) begin
        #1;
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
                chk("wr_data", mem_wdata, mon_e.data);
            end
        end
        if (mem_we2 === 1'b1) we2_cnt++;
    end

    // Reference: header, little-endian words, XOR checksum (optionally corrupted).
    task automatic make_stream(input logic [7:0] csum_xor);
        logic [7:0] cs;
        int n;
        n = words_q.size();
        stim_q.delete();
        stim_q.push_back(8'(n));
        stim_q.push_back(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) stim_q.push_back(words_q[i][8*k +: 8]);
            exp_q.push_back('{addr: i, data: words_q[i]});
        end
        cs = 8'h00;
        foreach (stim_q[i]) cs = cs ^ stim_q[i];
        stim_q.push_back(cs ^ csum_xor);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int  waited;
        bit  rdy;
        bit  taken;
        waited = 0;
        taken  = 0;
        rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        rx_valid = 1'b1;
        rx_data  = b;
        while (!taken) begin
            @(negedge clk);
            rdy = rx_ready;
            @(posedge clk);
            #1;
            if (rdy) taken = 1;
            else begin
                waited++;
                if (waited > 16) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL accept_timeout: rx_ready stayed 0, expected 1");
                    taken = 1;
                end
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_stream(input int max_gap, input int count);
        for (int i = 0; i < count && i < stim_q.size(); i++)
            send_byte(stim_q[i], $urandom_range(0, max_gap));
    endtask

    task automatic check_end(input bit exp_done);
        chk("load_done", 32'(load_done), 32'(exp_done));
        chk("load_err", 32'(load_err), 32'(!exp_done));
        chk("core_rst_n", 32'(core_rst_n), 32'(exp_done));
        chk("rx_ready_end", 32'(rx_ready), 32'd0);
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic restart();
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
        chk("restart_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("restart_done", 32'(load_done), 32'd0);
        chk("restart_err", 32'(load_err), 32'd0);
        chk("restart_ready", 32'(rx_ready), 32'd1);
    endtask

    task automatic set_fixed_words();
        words_q.delete();
        words_q.push_back(32'h0000_0013);
        words_q.push_back(32'h0000_006F);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bad;
        int n;

        sys_rst = 1'b1;
        #1;
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_load_err", 32'(load_err), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        sys_rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);

        // Two-word image, good checksum (0x7E).
        set_fixed_words();
        make_stream(8'h00);
        chk("csum_ref", 32'(stim_q[stim_q.size()-1]), 32'h7E);
        send_stream(0, stim_q.size());
        check_end(1'b1);

        // Same image with checksum 0x00: writes happen, then error.
        restart();
        set_fixed_words();
        make_stream(8'h7E);
        send_stream(0, stim_q.size());
        check_end(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("err_hold_core_rst_n", 32'(core_rst_n), 32'd0);
        restart();
        set_fixed_words();
        make_stream(8'h00);
        send_stream(1, stim_q.size());
        check_end(1'b1);

        // Empty image.
        restart();
        words_q.delete();
        make_stream(8'h00);
        send_stream(0, stim_q.size());
        check_end(1'b1);

        // Gapped stream, with an ignored load_req mid-stream.
        restart();
        set_fixed_words();
        make_stream(8'h00);
        send_stream(5, 5);
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
        chk("ignored_req_ready", 32'(rx_ready), 32'd1);
        for (int i = 5; i < stim_q.size(); i++) send_byte(stim_q[i], $urandom_range(0, 5));
        check_end(1'b1);

        // Random images.
        for (int t = 0; t < 8; t++) begin
            restart();
            n = $urandom_range(1, 8);
            words_q.delete();
            for (int i = 0; i < n; i++) words_q.push_back($urandom);
            bad = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            make_stream(bad);
            send_stream(3, stim_q.size());
            check_end(bad == 8'h00);
        end

        // Reset after byte 7: only word 0 is ever written.
        restart();
        set_fixed_words();
        make_stream(8'h00);
        void'(exp_q.pop_back());
        send_stream(5, 7);
        sys_rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("midrst_mem_we", 32'(mem_we), 32'd0);
        end
        chk("midrst_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("midrst_done", 32'(load_done), 32'd0);
        chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
        chk("pending_midrst", 32'(exp_q.size()), 32'd0);
        sys_rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ready", 32'(rx_ready), 32'd1);
        set_fixed_words();
        make_stream(8'h00);
        send_stream(2, stim_q.size());
        check_end(1'b1);

        // ADDR_W=2: 5 words overflows, 4 words is accepted.
        rx_valid2 = 1'b1;
        rx_data2  = 8'h05;
        @(posedge clk); #1;
        chk("ovf_len1_ready", 32'(rx_ready2), 32'd1);
        rx_data2  = 8'h00;
        @(posedge clk); #1;
        rx_valid2 = 1'b0;
        chk("ovf_ready", 32'(rx_ready2), 32'd0);
        chk("ovf_err", 32'(load_err2), 32'd1);
        chk("ovf_core_rst_n", 32'(core_rst_n2), 32'd0);
        chk("ovf_done", 32'(load_done2), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_no_write", 32'(we2_cnt), 32'd0);
        load_req2 = 1'b1;
        @(posedge clk); #1;
        load_req2 = 1'b0;
        rx_valid2 = 1'b1;
        rx_data2  = 8'h04;
        @(posedge clk); #1;
        rx_data2  = 8'h00;
        @(posedge clk); #1;
        rx_valid2 = 1'b0;
        chk("max_len_ready", 32'(rx_ready2), 32'd1);
        chk("max_len_err", 32'(load_err2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, instruction-memory word-address width (depth 2^ADDR_W words).
REQ-002 SHALL have port sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port sys_rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port rx_valid  input  1  byte available on rx_data.
REQ-005 SHALL have port rx_data  input  8  incoming program byte.
REQ-006 SHALL have port rx_ready  output  1  loader accepts a byte this cycle.
REQ-007 SHALL have port load_req  input  1  single-cycle request to restart a load.
REQ-008 SHALL have port mem_we  output  1  instruction-memory write strobe.
REQ-009 SHALL have port mem_addr  output  ADDR_W  word address of the write.
REQ-010 SHALL have port mem_wdata  output  32  instruction word to write.
REQ-011 SHALL have port core_rst_n  output  1  active-low reset to the core; low while loading.
REQ-012 SHALL have port load_done  output  1  image loaded and checksum matched.
REQ-013 SHALL have port load_err  output  1  length overflow or checksum mismatch.

Function
REQ-014 A byte SHALL be accepted only on a cycle where rx_valid and rx_ready are both 1.
REQ-015 Stream format SHALL be: LEN_LO, LEN_HI (16-bit word count N), N words of 4 bytes each (little-endian, byte 0 = bits 7:0), then one CSUM byte.
REQ-016 FSM states SHALL be LEN0, LEN1, DATA, CSUM, DONE, ERR; rx_ready=1 in LEN0/LEN1/DATA/CSUM, 0 in DONE/ERR.
REQ-017 Transitions SHALL be: LEN0->LEN1 on accept; LEN1->DATA if N>0, ->CSUM if N=0, ->ERR if N>2^ADDR_W (all on accept).
REQ-018 In DATA, a 2-bit byte index SHALL wrap 3->0; the word counter SHALL increment on every 4th accept; DATA->CSUM on the 4th byte of word N-1.
REQ-019 mem_we SHALL pulse high exactly one cycle, the cycle after the 4th byte of a word is accepted, with mem_addr = word index (0..N-1) and mem_wdata = assembled word.
REQ-020 mem_addr and mem_wdata SHALL hold their last values while mem_we=0.
REQ-021 The running checksum SHALL be the XOR of every accepted byte from LEN_LO through the last data byte.
REQ-022 On CSUM accept: equal -> DONE; unequal -> ERR.
REQ-023 In DONE, load_done=1 and core_rst_n=1, both registered, rising on the same edge as DONE entry.
REQ-024 In ERR, load_err=1 and core_rst_n SHALL remain 0.
REQ-025 load_req in DONE or ERR SHALL return the FSM to LEN0 next cycle, clear load_done/load_err/checksum/counters, and drive core_rst_n=0.
REQ-026 load_req in any other state SHALL be ignored.
REQ-027 rx_valid stalls (gaps) SHALL NOT alter state, counters or checksum.

Reset
REQ-028 While sys_rst=1: state=LEN0, rx_ready=1 after release, mem_we=0, mem_addr=0, mem_wdata=0, core_rst_n=0, load_done=0, load_err=0, counters and checksum=0.
REQ-029 sys_rst asserted mid-load SHALL abort immediately, with no further mem_we; written memory contents are not the loader's concern.

Structure
REQ-030 State encodings, header byte count (2) and word byte count (4) SHALL live in shared package/header loader_defs.
REQ-031 Byte-to-word assembly (index, shift register, word-complete flag) SHALL be one sub-module, inst_loader_packer; FSM, checksum and address counter stay in inst_loader.

Verification
REQ-032 Reset then stream 02 00 | 13 00 00 00 | 6F 00 00 00 | CSUM=7E -> writes addr0=0x00000013, addr1=0x0000006F, then load_done=1, core_rst_n=1, load_err=0.
REQ-033 Same stream with CSUM=00 -> both writes occur, load_err=1, core_rst_n stays 0; then load_req plus the correct stream -> load_done=1.
REQ-034 Stream 00 00 | CSUM=00 -> no mem_we pulse, load_done=1.
REQ-035 ADDR_W=2, header 05 00 -> ERR after second byte, no mem_we, rx_ready=0.
REQ-036 REQ-032 stream with random 0-5 cycle rx_valid gaps -> identical writes and result; sys_rst asserted after byte 7 -> mem_we=0 from then on, core_rst_n=0, state LEN0.
